// File: rtl/musa_pkg.sv
// Shared constants for the multiply/divide responder: R-type func codes
// handled outside the combinational alu, and the muldiv FSM state encoding.
package musa_pkg;

    localparam logic [5:0] FUNC_MTHI  = 6'h11;
    localparam logic [5:0] FUNC_MTLO  = 6'h13;
    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_DIV   = 6'h1A;
    localparam logic [5:0] FUNC_DIVU  = 6'h1B;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/muldiv_iter.sv
// One iteration of the magnitude datapath.
//   div_mode_i=0: shift-add multiply step. acc = {partial_hi, multiplier}; the
//                 addend is added into the upper half when acc[0] is set, then
//                 the whole accumulator shifts right by one.
//   div_mode_i=1: restoring divide step. acc = {remainder, dividend/quotient};
//                 shift left by one, subtract the divisor when it fits and shift
//                 the resulting quotient bit into the bottom.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    input  logic               div_mode_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Next accumulator for either mode; the divide difference is taken modulo
    // 2^WIDTH because when it fits the true result is always below the divisor.
    always_comb begin
        sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
        fits   = (rem_sh >= {1'b0, opnd_i});
        diff   = rem_sh[WIDTH-1:0] - opnd_i;
        acc_o  = {sum, acc_i[WIDTH-1:1]};
        if (div_mode_i) begin
            if (fits) begin
                acc_o = {diff, acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide responder owning the HI/LO registers.
// Operands are reduced to magnitudes on accept, iterated one bit per cycle,
// and sign-corrected in FIX before HI/LO are written on entry to DONE.
// Build option: MULDIV_FAST_MUL_EN -- MULT/MULTU use a single-cycle
// WIDTHxWIDTH multiplier and go straight from IDLE to DONE.
module muldiv_unit
    import musa_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   opnd_q;
    logic [5:0]         func_q;
    logic               neg_res_q, neg_rem_q;
    logic               busy_q, done_q, dbz_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               is_mul, is_div, is_signed, sign_a, sign_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .acc_i      (acc_q),
        .opnd_i     (opnd_q),
        .div_mode_i (state_q == S_DIV),
        .acc_o      (acc_d)
    );

    // Decode the incoming request and form operand magnitudes.
    always_comb begin
        is_mul    = (func == FUNC_MULT) || (func == FUNC_MULTU);
        is_div    = (func == FUNC_DIV)  || (func == FUNC_DIVU);
        is_signed = (func == FUNC_MULT) || (func == FUNC_DIV);
        sign_a    = is_signed & data_a[WIDTH-1];
        sign_b    = is_signed & data_b[WIDTH-1];
        abs_a     = sign_a ? -data_a : data_a;
        abs_b     = sign_b ? -data_b : data_b;
    end

    // Sign correction of the finished magnitude result.
    always_comb begin
        prod_fix = neg_res_q ? -acc_q : acc_q;
        quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_mag, fast_prod;

    // Single-cycle magnitude product, sign applied immediately.
    always_comb begin
        fast_mag  = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
        fast_prod = (sign_a ^ sign_b) ? -fast_mag : fast_mag;
    end
`endif

    // Sequencing FSM with registered busy/done/div_by_zero and HI/LO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            func_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        func_q    <= func;
                        neg_res_q <= sign_a ^ sign_b;
                        neg_rem_q <= sign_a;
                        cnt_q     <= '0;
                        if (is_mul) begin
`ifdef MULDIV_FAST_MUL_EN
                            {hi_q, lo_q} <= fast_prod;
                            state_q      <= S_DONE;
                            done_q       <= 1'b1;
`else
                            acc_q   <= {{WIDTH{1'b0}}, abs_b};
                            opnd_q  <= abs_a;
                            state_q <= S_MUL;
                            busy_q  <= 1'b1;
`endif
                        end else if (is_div) begin
                            if (data_b == '0) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                dbz_q   <= 1'b1;
                            end else begin
                                acc_q   <= {{WIDTH{1'b0}}, abs_a};
                                opnd_q  <= abs_b;
                                state_q <= S_DIV;
                                busy_q  <= 1'b1;
                            end
                        end else if (func == FUNC_MTHI) begin
                            hi_q    <= data_a;
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else if (func == FUNC_MTLO) begin
                            lo_q    <= data_a;
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if ((func_q == FUNC_MULT) || (func_q == FUNC_MULTU)) begin
                        {hi_q, lo_q} <= prod_fix;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver pushes expected HI/LO,
// div_by_zero and done timing from an arithmetic model; a monitor pops and
// compares on every done pulse. Honours MULDIV_FAST_MUL_EN for mul latency.
module tb_muldiv_unit;

    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_BAD   = 6'h20;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  func = '0;
    logic [31:0] data_a = '0;
    logic [31:0] data_b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .func        (func),
        .data_a      (data_a),
        .data_b      (data_b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: plain arithmetic on the architectural HI/LO.
    task automatic model_push(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        exp_t               e;
        logic signed [63:0] sa64, sb64;
        logic signed [31:0] sa, sb;
        e.dbz = 1'b0;
        e.due = cyc + 1;
        case (f)
            F_MULTU: begin
                {m_hi, m_lo} = {32'b0, a} * {32'b0, b};
                e.due = cyc + MUL_LAT;
            end
            F_MULT: begin
                sa64 = $signed({{32{a[31]}}, a});
                sb64 = $signed({{32{b[31]}}, b});
                {m_hi, m_lo} = sa64 * sb64;
                e.due = cyc + MUL_LAT;
            end
            F_DIVU: begin
                if (b == 0) e.dbz = 1'b1;
                else begin
                    m_lo = a / b;
                    m_hi = a % b;
                    e.due = cyc + DIV_LAT;
                end
            end
            F_DIV: begin
                if (b == 0) e.dbz = 1'b1;
                else begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        m_lo = 32'h8000_0000;
                        m_hi = 32'h0;
                    end else begin
                        sa = a;
                        sb = b;
                        m_lo = sa / sb;
                        m_hi = sa % sb;
                    end
                    e.due = cyc + DIV_LAT;
                end
            end
            F_MTHI: m_hi = a;
            F_MTLO: m_lo = a;
            default: return;
        endcase
        e.hi = m_hi;
        e.lo = m_lo;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        func   = f;
        data_a = a;
        data_b = b;
        model_push(f, a, b);
        @(negedge clock);
        start  = 1'b0;
        func   = '0;
        data_a = $urandom();
        data_b = $urandom();
    endtask

    // Waits for the done pulse, then one more cycle so the unit is back in IDLE.
    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done required=done", name);
            exp_q.delete();
        end
        @(negedge clock);
    endtask

    // Monitor / scoreboard.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=done required=none (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                chk("hi", hi, e.hi);
                chk("lo", lo, e.lo);
                chk("div_by_zero", div_by_zero, e.dbz);
                chk("latency_cycle", cyc, e.due);
                chk("busy_in_done", busy, 0);
            end
        end
    end

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return $urandom_range(1, 15);
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin : stim
        logic [5:0]  funcs[7];
        logic [5:0]  f;
        logic [31:0] a, b;
        int          d0;
        funcs = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO, F_BAD};

        repeat (2) @(negedge clock);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_dbz", div_by_zero, 0);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        reset = 1'b1;
        @(negedge clock);

        issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("busy_after_accept", busy, (MUL_LAT > 1));
        wait_done("multu_max");
        issue(F_MULT, 32'hFFFF_FFFE, 32'h3);
        wait_done("mult_neg");
        issue(F_DIV, 32'hFFFF_FFF9, 32'h2);
        chk("busy_div", busy, 1);
        wait_done("div_neg");
        issue(F_DIVU, 32'h7, 32'h2);
        wait_done("divu");
        issue(F_MTHI, 32'h1234, 32'h0);
        wait_done("mthi");
        issue(F_MTLO, 32'h5678, 32'h0);
        wait_done("mtlo");
        issue(F_DIVU, 32'h5, 32'h0);
        wait_done("divu_zero");
        issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_overflow");
        issue(F_MTHI, 32'hDEAD_BEEF, 32'h0);
        wait_done("mthi2");
        issue(F_MTLO, 32'hCAFE_F00D, 32'h0);
        wait_done("mtlo2");

        d0 = done_cnt;
        issue(F_BAD, 32'h1, 32'h1);
        repeat (5) @(negedge clock);
        chk("bad_func_no_done", done_cnt, d0);
        chk("bad_func_busy", busy, 0);

        issue(F_MULT, 32'h1234_5678, 32'h8765_4321);
        repeat (4) @(negedge clock);
        if (MUL_LAT == 1) begin
            issue(F_DIV, 32'h64, 32'h7);
        end else begin
            start = 1'b1; func = F_DIV; data_a = 32'h64; data_b = 32'h7;
            @(negedge clock);
            start = 1'b0;
        end
        wait_done("mult_with_ignored_start");
        repeat (2) @(negedge clock);

        issue(F_DIVU, 32'hABCD_0123, 32'h0000_0345);
        repeat (9) @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        m_hi = '0;
        m_lo = '0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        @(negedge clock);
        reset = 1'b1;
        d0 = done_cnt;
        repeat (40) @(negedge clock);
        chk("no_done_after_abort", done_cnt, d0);

        for (int i = 0; i < 60; i++) begin
            f = funcs[$urandom_range(0, 6)];
            a = rnd_opnd();
            b = rnd_opnd();
            if (f == F_BAD) begin
                d0 = done_cnt;
                issue(f, a, b);
                repeat (3) @(negedge clock);
                chk("rand_bad_no_done", done_cnt, d0);
            end else begin
                issue(f, a, b);
                wait_done("rand_op");
            end
        end

        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
